// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and
// transaction owner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_starve_pick.sv
// Data-first pick with a saturating starvation counter that hands the port
// to fetch after IF_MAX_WAIT consecutive data grants with fetch waiting.
module arb_starve_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int IF_MAX_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_strobe,
  output logic grant_fetch,
  output logic grant_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(IF_MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_data   = d_req & ~(if_req & (starve_cnt_q == MAX_CNT));
    grant_fetch  = if_req & ~grant_data;
    starve_cnt_d = starve_cnt_q;
    if (grant_strobe) begin
      if (grant_fetch) begin
        starve_cnt_d = '0;
      end else if (grant_data && if_req && (starve_cnt_q != MAX_CNT)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, running one
// req/gnt/rvalid transaction at a time and returning per-requester acks.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_ADDR  = 32,
  parameter int IF_MAX_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [WIDTH_ADDR-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_ack,
  output logic [WIDTH_DATA-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WIDTH_ADDR-1:0] d_addr,
  input  logic [WIDTH_DATA-1:0] d_wdata,
  output logic                  d_ack,
  output logic [WIDTH_DATA-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [WIDTH_DATA-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [WIDTH_DATA-1:0] mem_rdata
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  kill_q, kill_d;
  logic                  we_q, we_d;
  logic [WIDTH_ADDR-1:0] addr_q, addr_d;
  logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [WIDTH_DATA-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH_DATA-1:0] d_rdata_q, d_rdata_d;

  logic grant_strobe, grant_fetch, grant_data, fetch_flush;

  assign grant_strobe = (state_q == ST_IDLE) && (if_req || d_req);
  assign fetch_flush  = if_flush && (owner_q == OWN_FETCH);

  arb_starve_pick #(
    .IF_MAX_WAIT (IF_MAX_WAIT),
    .CNT_W       (CNT_W)
  ) u_pick (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .d_req        (d_req),
    .grant_strobe (grant_strobe),
    .grant_fetch  (grant_fetch),
    .grant_data   (grant_data)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    kill_d     = kill_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d = ST_REQ;
          owner_d = OWN_DATA;
          kill_d  = 1'b0;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (grant_fetch) begin
          state_d = ST_REQ;
          owner_d = OWN_FETCH;
          kill_d  = 1'b0;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
        end
      end
      ST_REQ: begin
        if (mem_gnt)     state_d = ST_RESP;
        if (fetch_flush) kill_d  = 1'b1;
      end
      ST_RESP: begin
        if (fetch_flush) kill_d = 1'b1;
        if (mem_rvalid) begin
          state_d = ST_DONE;
          // A killed fetch must not disturb the last acknowledged instruction.
          if (owner_q == OWN_DATA)              d_rdata_d  = we_q ? '0 : mem_rdata;
          else if (!kill_q && !fetch_flush)     if_rdata_d = mem_rdata;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      kill_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      kill_q     <= kill_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack   = (state_q == ST_DONE) && (owner_q == OWN_FETCH) && !kill_q && !if_flush;
  assign d_ack    = (state_q == ST_DONE) && (owner_q == OWN_DATA);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a bench-side memory image supplies
// read data, expected rdata is queued per requester and popped on each ack.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WIDTH_DATA (32),
    .WIDTH_ADDR (32),
    .IF_MAX_WAIT(4),
    .CNT_W      (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .if_stall   (if_stall),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_stall    (d_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return 32'h0;
  endfunction

  // Entered at posedge+1 of the IDLE cycle with the request already driven.
  // Walks REQ (with gnt_delay stalled cycles), RESP and DONE, then returns at
  // posedge+1 of the following IDLE cycle.
  task automatic run_txn(input string nm, input bit exp_fetch, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [31:0] exp_wdata,
                         input int gnt_delay, input bit flush_resp, input bit exp_ack);
    logic [31:0] e;
    @(negedge clk);
    total++;
    if ((exp_fetch ? if_stall : d_stall) !== 1'b1) begin
      bad++; $display("FAIL %s idle_stall got=%b want=1", nm, exp_fetch ? if_stall : d_stall);
    end
    @(posedge clk); #1;
    for (int i = 0; i < gnt_delay; i++) begin
      mem_gnt = 1'b0;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we ||
          (exp_we && mem_wdata !== exp_wdata) || if_ack !== 1'b0 || d_ack !== 1'b0) begin
        bad++;
        $display("FAIL %s hold%0d got req=%b addr=%h we=%b wdata=%h acks=%b%b want req=1 addr=%h we=%b wdata=%h acks=00",
                 nm, i, mem_req, mem_addr, mem_we, mem_wdata, if_ack, d_ack, exp_addr, exp_we, exp_wdata);
      end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we ||
        (exp_we && mem_wdata !== exp_wdata)) begin
      bad++;
      $display("FAIL %s req got req=%b addr=%h we=%b wdata=%h want req=1 addr=%h we=%b wdata=%h",
               nm, mem_req, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata);
    end
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    if (exp_we) begin
      mem_img[exp_addr] = exp_wdata;
      mem_rdata = $urandom;
      if (exp_ack) d_exp_q.push_back(32'h0);
    end else begin
      mem_rdata = mem_read(exp_addr);
      if (exp_ack) begin
        if (exp_fetch) if_exp_q.push_back(mem_rdata);
        else           d_exp_q.push_back(mem_rdata);
      end
    end
    if (flush_resp) if_flush = 1'b1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL %s resp got req=%b acks=%b%b want req=0 acks=00", nm, mem_req, if_ack, d_ack);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    if_flush   = 1'b0;
    @(negedge clk);
    total++;
    if (!exp_ack) begin
      if (if_ack !== 1'b0 || d_ack !== 1'b0) begin
        bad++; $display("FAIL %s done_noack got acks=%b%b want 00", nm, if_ack, d_ack);
      end
    end else if (exp_fetch) begin
      e = (if_exp_q.size() != 0) ? if_exp_q.pop_front() : 32'hx;
      if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== e || if_stall !== 1'b0) begin
        bad++;
        $display("FAIL %s if_done got if_ack=%b d_ack=%b rdata=%h stall=%b want 1 0 %h 0",
                 nm, if_ack, d_ack, if_rdata, if_stall, e);
      end
    end else begin
      e = (d_exp_q.size() != 0) ? d_exp_q.pop_front() : 32'hx;
      if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== e || d_stall !== 1'b0) begin
        bad++;
        $display("FAIL %s d_done got d_ack=%b if_ack=%b rdata=%h stall=%b want 1 0 %h 0",
                 nm, d_ack, if_ack, d_rdata, d_stall, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, if_stall, d_stall} !== '0) begin
      bad++;
      $display("FAIL reset got req=%b we=%b addr=%h wdata=%h acks=%b%b ird=%h drd=%h want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    run_txn("fetch10", 1'b1, 32'h10, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    run_txn("store20", 1'b0, 32'h20, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b1);
    d_we = 1'b0; d_wdata = 32'h0;
    run_txn("load20", 1'b0, 32'h20, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if (d_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rdata_hold got=%h want=deadbeef", d_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h12345678;
    run_txn("bp_store", 1'b0, 32'h30, 1'b1, 32'h12345678, 5, 1'b0, 1'b1);
    d_we = 1'b0;
    run_txn("bp_load", 1'b0, 32'h30, 1'b0, 32'h0, 3, 1'b0, 1'b1);
    d_req = 1'b0;
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h40;
    run_txn("flush40", 1'b1, 32'h40, 1'b0, 32'h0, 0, 1'b1, 1'b0);
    if_addr = 32'h80;
    run_txn("fetch80", 1'b1, 32'h80, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h60;
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    #1;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid got req=%b we=%b addr=%h acks=%b%b ird=%h drd=%h want all 0",
               mem_req, mem_we, mem_addr, if_ack, d_ack, if_rdata, d_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
        bad++; $display("FAIL reset_quiet%0d got acks=%b%b req=%b want 000", i, if_ack, d_ack, mem_req);
      end
    end
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    run_txn("post_reset", 1'b1, 32'h10, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic test_contention();
    bit order_q[$];
    bit f;
    order_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      f = order_q.pop_front();
      run_txn($sformatf("cont%0d", i), f, f ? 32'h100 : 32'h200, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    mem_img[32'h10]  = 32'h00500093;
    mem_img[32'h40]  = 32'h00000013;
    mem_img[32'h80]  = 32'h00A00113;
    mem_img[32'h100] = 32'h00100073;
    mem_img[32'h200] = 32'hCAFE0001;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage RV32I pipeline, for configurations with unified instruction/data memory.
- Sequences one outstanding transaction at a time over a req/gnt/rvalid memory interface.
- Returns per-requester acknowledges and stall outputs that feed the hazard unit.

Parameters:
- WIDTH_DATA, 32, data bus width.
- WIDTH_ADDR, 32, address bus width.
- IF_MAX_WAIT, 4, number of consecutive data grants with fetch pending, after which fetch wins.
- CNT_W, 3, starvation counter width (must hold IF_MAX_WAIT).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  WIDTH_ADDR  fetch address.
- if_flush  in  1  pipeline redirect; kills an in-flight fetch.
- if_ack  out  1  one-cycle pulse, fetch data valid.
- if_rdata  out  WIDTH_DATA  fetched instruction.
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WIDTH_ADDR  data address.
- d_wdata  in  WIDTH_DATA  store data.
- d_ack  out  1  one-cycle pulse, transaction done.
- d_rdata  out  WIDTH_DATA  load data (0 for stores).
- d_stall  out  1  d_req & ~d_ack.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable.
- mem_addr  out  WIDTH_ADDR  address.
- mem_wdata  out  WIDTH_DATA  write data.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  response valid; exactly one per accepted request, at least 1 cycle after gnt.
- mem_rdata  in  WIDTH_DATA  response data.

Behaviour:
- Reset: state=IDLE, owner=NONE, kill=0, starve_cnt=0. All outputs 0: mem_*, if_ack, d_ack, if_rdata, d_rdata. Stalls follow their combinational definition.
- FSM IDLE→REQ→RESP→DONE→IDLE.
- IDLE:
  - If d_req or if_req, choose the winner and register owner, we, addr, and wdata. Next state is REQ.
  - Fetch requests always register we=0.
- Arbitration:
  - Data wins if d_req and not (if_req & starve_cnt==IF_MAX_WAIT).
  - Otherwise fetch wins if if_req.
- Starvation counter:
  - Increments (saturating) on each data grant while if_req=1.
  - Clears on any fetch grant.
- REQ:
  - mem_req=1. mem_we, mem_addr, and mem_wdata are held stable from the registers.
  - On mem_gnt, go to RESP. mem_req drops the next cycle.
  - Inputs d_*/if_* are not re-sampled in REQ.
- RESP:
  - Wait for mem_rvalid, then register mem_rdata into the owner's rdata register.
  - For a store, d_rdata=0.
  - Next state is DONE.
- DONE:
  - Pulse the owner's ack for exactly one cycle, unless the transaction is fetch-owned with kill=1.
  - Return to IDLE and clear kill.
  - The requester drops or changes its req in the cycle after ack; IDLE samples fresh inputs.
- Latency: with gnt in the REQ cycle and rvalid the following cycle, the ack comes 3 cycles after req is first seen in IDLE. Throughput is 4 cycles per transaction minimum.
- if_flush:
  - Owner=fetch and state in REQ/RESP/DONE: set kill (or suppress the ack in DONE). The memory transaction still completes; no if_ack is issued.
  - Flush in IDLE or with owner=data: no effect.
- Simultaneous d_req and if_req in IDLE: resolved by the arbitration rule above. The loser sees its stall stay high.
- rdata registers hold their last value between acks.
- Reset mid-transaction: immediate return to IDLE with no ack. Memory shares rst_n, so no stale rvalid is expected.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2, DONE=2'd3) and owner encoding (NONE=2'd0, FETCH=2'd1, DATA=2'd2).
- One natural sub-module, arb_starve_pick: fixed-priority pick plus the saturating starvation counter. It takes if_req, d_req, and grant_strobe, and outputs grant_fetch and grant_data.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, gnt same cycle, rvalid next cycle with rdata=0x00500093 → mem_addr=0x10, mem_we=0; if_ack 3 cycles after req with if_rdata=0x00500093; if_stall high until the ack cycle.
- Store then load: d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF → mem_we=1, d_ack, d_rdata=0. Then a load from 0x20 returns 0xDEADBEEF on d_ack.
- Contention: if_req and d_req both held continuously with IF_MAX_WAIT=4 → grant order D,D,D,D,F,D,D,D,D,F; starve_cnt returns to 0 after each fetch grant.
- Flush: fetch 0x40 granted, if_flush pulsed during RESP → mem transaction completes, no if_ack. New fetch 0x80 is then served with if_ack.
- Backpressure: mem_gnt held low 5 cycles → mem_req, mem_addr, and mem_wdata stay stable for all 5 cycles; no ack until rvalid.
- Reset mid-RESP: rst_n low for 1 cycle → all outputs 0, state IDLE, no ack; a subsequent request completes normally.
